// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO: read-mode constants and the
// occupancy-field width helper.
package sync_fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Occupancy must represent 0..DEPTH inclusive, hence depth+1 values.
    function automatic int calc_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read
// port. Contents are deliberately not reset.
module sync_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_reg[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_reg[raddr_i];

endmodule

// File: rtl/sync_fifo_pro.sv
// Single-clock FIFO with occupancy count, programmable almost-full/empty
// thresholds, sticky overflow/underflow flags and selectable FWFT read mode.
module sync_fifo_pro
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int FWFT  = FIFO_STD,
    parameter int CNT_W = calc_cnt_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rdata_o,
    input  logic [CNT_W-1:0] af_level_i,
    input  logic [CNT_W-1:0] ae_level_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic             overflow_o,
    output logic             underflow_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;
    logic [WIDTH-1:0] rdata_reg, rdata_next;
    logic [WIDTH-1:0] mem_rdata;
    logic             rd_acc, wr_acc, mem_we;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o        = (count_reg == '0);
    assign full_o         = (count_reg == CNT_W'(DEPTH));
    assign almost_full_o  = (count_reg >= af_level_i);
    assign almost_empty_o = (count_reg <= ae_level_i);
    assign count_o        = count_reg;
    assign overflow_o     = ovf_reg;
    assign underflow_o    = unf_reg;

    // A full FIFO still accepts a write when the same cycle pops a word.
    assign rd_acc = rd_en_i && !empty_o;
    assign wr_acc = wr_en_i && (!full_o || rd_acc);
    assign mem_we = wr_acc && !clr_i && !rst_i;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        ovf_next    = ovf_reg;
        unf_next    = unf_reg;
        rdata_next  = rdata_reg;
        if (clr_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            ovf_next    = 1'b0;
            unf_next    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_next = ptr_inc(wr_ptr_reg);
            end
            if (rd_acc) begin
                rd_ptr_next = ptr_inc(rd_ptr_reg);
                rdata_next  = mem_rdata;
            end
            if (wr_acc && !rd_acc) begin
                count_next = count_reg + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count_next = count_reg - 1'b1;
            end
            if (wr_en_i && !wr_acc) begin
                ovf_next = 1'b1;
            end
            if (rd_en_i && empty_o) begin
                unf_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            ovf_reg    <= ovf_next;
            unf_reg    <= unf_next;
            rdata_reg  <= rdata_next;
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_reg),
        .wdata_i (wdata_i),
        .raddr_i (rd_ptr_reg),
        .rdata_o (mem_rdata)
    );

    // The popped-word register doubles as the FWFT hold value when empty.
    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            assign rdata_o = empty_o ? rdata_reg : mem_rdata;
        end else begin : g_std
            assign rdata_o = rdata_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_pro.sv
// Self-checking bench: a registered-read and an FWFT instance share stimulus
// and are compared every cycle against a queue-based model of the FIFO.
module tb_sync_fifo_pro;
    import sync_fifo_pkg::*;

    localparam int W     = 32;
    localparam int D     = 5;
    localparam int CW    = calc_cnt_w(D);

    logic          clk = 1'b0;
    logic          rst = 1'b1, clr = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic [CW-1:0] af_lvl = CW'(4), ae_lvl = CW'(1);

    logic [W-1:0]  s_rdata, f_rdata;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [CW-1:0] s_cnt, f_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [W-1:0] q[$];
    logic         m_ovf = 1'b0, m_unf = 1'b0;
    logic [W-1:0] m_std_rdata = '0;

    always #5 clk = ~clk;

    sync_fifo_pro #(.WIDTH(W), .DEPTH(D), .FWFT(FIFO_STD)) u_std (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .wdata_i(wdata),
        .wr_en_i(wr), .rd_en_i(rd), .rdata_o(s_rdata),
        .af_level_i(af_lvl), .ae_level_i(ae_lvl),
        .full_o(s_full), .empty_o(s_empty), .almost_full_o(s_af),
        .almost_empty_o(s_ae), .overflow_o(s_ovf), .underflow_o(s_unf),
        .count_o(s_cnt)
    );

    sync_fifo_pro #(.WIDTH(W), .DEPTH(D), .FWFT(FIFO_FWFT)) u_fwft (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .wdata_i(wdata),
        .wr_en_i(wr), .rd_en_i(rd), .rdata_o(f_rdata),
        .af_level_i(af_lvl), .ae_level_i(ae_lvl),
        .full_o(f_full), .empty_o(f_empty), .almost_full_o(f_af),
        .almost_empty_o(f_ae), .overflow_o(f_ovf), .underflow_o(f_unf),
        .count_o(f_cnt)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update from the inputs sampled at the edge just taken.
    task automatic model_edge();
        bit rd_acc, wr_acc;
        if (rst) begin
            q.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_std_rdata = '0;
        end else if (clr) begin
            q.delete();
            m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            rd_acc = rd && (q.size() > 0);
            wr_acc = wr && ((q.size() < D) || rd_acc);
            if (rd && q.size() == 0) m_unf = 1'b1;
            if (wr && !wr_acc)       m_ovf = 1'b1;
            if (rd_acc) m_std_rdata = q.pop_front();
            if (wr_acc) q.push_back(wdata);
        end
    endtask

    task automatic compare_all();
        int cnt = q.size();
        check("std_count", W'(s_cnt), W'(cnt));
        check("fwft_count", W'(f_cnt), W'(cnt));
        check("std_empty", W'(s_empty), W'(cnt == 0));
        check("fwft_empty", W'(f_empty), W'(cnt == 0));
        check("std_full", W'(s_full), W'(cnt == D));
        check("fwft_full", W'(f_full), W'(cnt == D));
        check("std_af", W'(s_af), W'(cnt >= int'(af_lvl)));
        check("fwft_af", W'(f_af), W'(cnt >= int'(af_lvl)));
        check("std_ae", W'(s_ae), W'(cnt <= int'(ae_lvl)));
        check("fwft_ae", W'(f_ae), W'(cnt <= int'(ae_lvl)));
        check("std_ovf", W'(s_ovf), W'(m_ovf));
        check("fwft_ovf", W'(f_ovf), W'(m_ovf));
        check("std_unf", W'(s_unf), W'(m_unf));
        check("fwft_unf", W'(f_unf), W'(m_unf));
        check("std_rdata", s_rdata, m_std_rdata);
        if (cnt > 0) check("fwft_rdata", f_rdata, q[0]);
    endtask

    task automatic step(input bit r, input bit c, input bit w, input bit rr, input logic [W-1:0] d);
        rst = r; clr = c; wr = w; rd = rr; wdata = d;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        $display("cyc rst=%0b clr=%0b wr=%0b rd=%0b wd=%h cnt=%0d std_rd=%h fwft_rd=%h",
                 r, c, w, rr, d, s_cnt, s_rdata, f_rdata);
    endtask

    initial begin
        int exp_af[6] = '{0, 0, 0, 0, 1, 1};
        int exp_ae[6] = '{1, 1, 0, 0, 0, 0};

        step(1, 0, 0, 0, '0);
        check("rst_count", W'(s_cnt), 32'd0);
        check("rst_empty", W'(s_empty), 32'd1);
        check("rst_rdata", s_rdata, 32'd0);

        // Basic ordering through registered read
        step(0, 0, 1, 0, 32'h11);
        step(0, 0, 1, 0, 32'h22);
        step(0, 0, 1, 0, 32'h33);
        step(0, 0, 0, 1, '0); check("seq_rd1", s_rdata, 32'h11);
        step(0, 0, 0, 1, '0); check("seq_rd2", s_rdata, 32'h22);
        step(0, 0, 0, 1, '0); check("seq_rd3", s_rdata, 32'h33);
        check("seq_empty", W'(s_empty), 32'd1);

        // Fill, overflow, simultaneous read/write while full across wrap
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 32'hA0 + i);
        check("fill_full", W'(s_full), 32'd1);
        check("fill_count", W'(s_cnt), 32'd5);
        step(0, 0, 1, 0, 32'hEE);
        check("ovf_set", W'(s_ovf), 32'd1);
        check("ovf_count", W'(s_cnt), 32'd5);
        step(0, 0, 1, 1, 32'hB0);
        check("rw_full_count", W'(s_cnt), 32'd5);
        check("rw_full_rdata", s_rdata, 32'hA0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, '0);
        check("wrap_last", s_rdata, 32'hB0);

        // Underflow and clear
        step(0, 0, 0, 1, '0);
        check("unf_set", W'(s_unf), 32'd1);
        check("unf_rdata", s_rdata, 32'hB0);
        step(0, 1, 1, 1, 32'h99);
        check("clr_unf", W'(s_unf), 32'd0);
        check("clr_ovf", W'(s_ovf), 32'd0);
        check("clr_count", W'(s_cnt), 32'd0);

        // Threshold flags across count 0..5
        for (int c = 0; c <= 5; c++) begin
            check("lvl_af", W'(s_af), W'(exp_af[c]));
            check("lvl_ae", W'(s_ae), W'(exp_ae[c]));
            if (c < 5) step(0, 0, 1, 0, 32'h40 + c);
        end
        step(0, 1, 0, 0, '0);

        // FWFT zero-latency head
        step(0, 0, 1, 0, 32'hA5);
        check("fwft_head", f_rdata, 32'hA5);
        check("fwft_nempty", W'(f_empty), 32'd0);
        step(0, 0, 0, 1, '0);
        check("fwft_pop_empty", W'(f_empty), 32'd1);

        // Reset mid-operation with a write pending
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 32'h70 + i);
        step(1, 0, 1, 0, 32'h77);
        check("midrst_count", W'(s_cnt), 32'd0);
        check("midrst_empty", W'(s_empty), 32'd1);
        check("midrst_ovf", W'(s_ovf), 32'd0);
        step(0, 0, 0, 0, '0);

        // Randomized traffic with occasional clear/reset and moving thresholds
        for (int i = 0; i < 2000; i++) begin
            if ((i % 50) == 0) begin
                af_lvl = CW'($urandom_range(0, (1 << CW) - 1));
                ae_lvl = CW'($urandom_range(0, (1 << CW) - 1));
            end
            step(($urandom_range(0, 255) == 0), ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
